key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_pkg.sv | 22 ++
 rtl/tick_gen.sv | 30 +++
 rtl/key_debounce.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM states,
// default timing constants and the counter-width helper.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_DEB = 3'd1,
    ST_HELD      = 3'd2,
    ST_LONG_HELD = 3'd3,
    ST_REL_DEB   = 3'd4
  } key_fsm_e;

  localparam int DEF_DEB_TICKS  = 20;
  localparam int DEF_LONG_TICKS = 1000;
  localparam int DEF_REP_TICKS  = 200;

  // Counter width able to hold the terminal value, with one bit of headroom.
  function automatic int cnt_width(input int ticks);
    return $clog2(ticks) + 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-clk tick every CLK_DIV+1 clk cycles.
module tick_gen
  import key_pkg::*;
#(
  parameter int CLK_DIV = 50*1000-1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] DIV_C = CW'(CLK_DIV);

  logic [CW-1:0] r_cnt;

  // Count 0..CLK_DIV and wrap; tick is the terminal-count compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_cnt == DIV_C) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == DIV_C);

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key debouncer with press/release/long-press/auto-repeat
// events. One shared tick prescaler; one independent FSM per key.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_IDLE      | key accepted as released, waiting for a pressed sample
//   ST_PRESS_DEB | pressed level seen, counting stable ticks
//   ST_HELD      | press accepted, counting hold ticks toward long press
//   ST_LONG_HELD | long press emitted, auto-repeat running
//   ST_REL_DEB   | released level seen, counting stable ticks; hold frozen
module key_debounce
  import key_pkg::*;
#(
  parameter int CLK_DIV    = 50*1000-1,
  parameter int KEY_NUM    = 4,
  parameter int DEB_TICKS  = DEF_DEB_TICKS,
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int REP_TICKS  = DEF_REP_TICKS,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_rep
);

  localparam int DW = cnt_width(DEB_TICKS);
  localparam int HW = cnt_width(LONG_TICKS);
  localparam int RW = cnt_width(REP_TICKS);
  localparam logic [DW-1:0] DEB_C  = DW'(DEB_TICKS);
  localparam logic [HW-1:0] LONG_C = HW'(LONG_TICKS);
  localparam logic [RW-1:0] REP_C  = RW'(REP_TICKS);
  // Raw pin level that means "not pressed"; the synchronizer resets to it.
  localparam logic [KEY_NUM-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

  logic               w_tick;
  logic [KEY_NUM-1:0] r_sync1;
  logic [KEY_NUM-1:0] r_sync2;
  logic [KEY_NUM-1:0] w_pressed;

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Two-flop synchronizer on the raw asynchronous pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= IDLE_LVL;
      r_sync2 <= IDLE_LVL;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  genvar g;
  generate
    for (g = 0; g < KEY_NUM; g++) begin : g_ch
      key_fsm_e      r_state;
      key_fsm_e      w_state_nxt;
      logic [DW-1:0] r_deb;
      logic [DW-1:0] w_deb_nxt;
      logic [DW-1:0] w_deb_inc;
      logic [HW-1:0] r_hold;
      logic [HW-1:0] w_hold_nxt;
      logic [HW-1:0] w_hold_inc;
      logic [RW-1:0] r_rep;
      logic [RW-1:0] w_rep_nxt;
      logic [RW-1:0] w_rep_inc;
      logic          w_in;
      logic          r_lvl;
      logic          w_lvl_nxt;
      logic          r_press;
      logic          w_press_nxt;
      logic          r_rel;
      logic          w_rel_nxt;
      logic          r_long;
      logic          w_long_nxt;
      logic          r_rep_p;
      logic          w_rep_p_nxt;

      assign w_in       = w_pressed[g];
      assign w_deb_inc  = r_deb + 1'b1;
      assign w_hold_inc = r_hold + 1'b1;
      assign w_rep_inc  = r_rep + 1'b1;

      // Next-state, counter and event decode for one channel.
      always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb;
        w_hold_nxt  = r_hold;
        w_rep_nxt   = r_rep;
        w_lvl_nxt   = r_lvl;
        w_press_nxt = 1'b0;
        w_rel_nxt   = 1'b0;
        w_long_nxt  = 1'b0;
        w_rep_p_nxt = 1'b0;
        unique case (r_state)
          ST_IDLE: begin
            if (w_in) begin
              w_state_nxt = ST_PRESS_DEB;
              w_deb_nxt   = '0;
            end
          end
          ST_PRESS_DEB: begin
            if (!w_in) begin
              w_state_nxt = ST_IDLE;
              w_deb_nxt   = '0;
            end else if (w_tick) begin
              if (w_deb_inc == DEB_C) begin
                w_state_nxt = ST_HELD;
                w_deb_nxt   = '0;
                w_hold_nxt  = '0;
                w_rep_nxt   = '0;
                w_lvl_nxt   = 1'b1;
                w_press_nxt = 1'b1;
              end else begin
                w_deb_nxt = w_deb_inc;
              end
            end
          end
          ST_HELD: begin
            if (!w_in) begin
              w_state_nxt = ST_REL_DEB;
              w_deb_nxt   = '0;
            end else if (w_tick) begin
              w_hold_nxt = w_hold_inc;
              if (w_hold_inc == LONG_C) begin
                w_state_nxt = ST_LONG_HELD;
                w_rep_nxt   = '0;
                w_long_nxt  = 1'b1;
              end
            end
          end
          ST_LONG_HELD: begin
            // Hold counter stays parked at LONG_C; it also marks the
            // state to return to after a rejected release.
            if (!w_in) begin
              w_state_nxt = ST_REL_DEB;
              w_deb_nxt   = '0;
            end else if (w_tick) begin
              if (w_rep_inc == REP_C) begin
                w_rep_nxt   = '0;
                w_rep_p_nxt = 1'b1;
              end else begin
                w_rep_nxt = w_rep_inc;
              end
            end
          end
          ST_REL_DEB: begin
            if (w_in) begin
              w_state_nxt = (r_hold == LONG_C) ? ST_LONG_HELD : ST_HELD;
              w_deb_nxt   = '0;
            end else if (w_tick) begin
              if (w_deb_inc == DEB_C) begin
                w_state_nxt = ST_IDLE;
                w_deb_nxt   = '0;
                w_hold_nxt  = '0;
                w_rep_nxt   = '0;
                w_lvl_nxt   = 1'b0;
                w_rel_nxt   = 1'b1;
              end else begin
                w_deb_nxt = w_deb_inc;
              end
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_deb_nxt   = '0;
            w_hold_nxt  = '0;
            w_rep_nxt   = '0;
            w_lvl_nxt   = 1'b0;
          end
        endcase
      end

      // State, counters and registered outputs for one channel.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state <= ST_IDLE;
          r_deb   <= '0;
          r_hold  <= '0;
          r_rep   <= '0;
          r_lvl   <= 1'b0;
          r_press <= 1'b0;
          r_rel   <= 1'b0;
          r_long  <= 1'b0;
          r_rep_p <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_deb   <= w_deb_nxt;
          r_hold  <= w_hold_nxt;
          r_rep   <= w_rep_nxt;
          r_lvl   <= w_lvl_nxt;
          r_press <= w_press_nxt;
          r_rel   <= w_rel_nxt;
          r_long  <= w_long_nxt;
          r_rep_p <= w_rep_p_nxt;
        end
      end

      assign key_state[g]   = r_lvl;
      assign key_press[g]   = r_press;
      assign key_release[g] = r_rel;
      assign key_long[g]    = r_long;
      assign key_rep[g]     = r_rep_p;
    end
  endgenerate

endmodule
